// File: rtl/seg_scan_4d_pkg.sv
// seg_scan_4d_pkg: shared constants for the 4-digit 7-segment scanner.
// Segment patterns are {g,f,e,d,c,b,a}, active-low.
package seg_scan_4d_pkg;

   localparam int IDX_W = 2;

   localparam logic [3:0] AN_OFF = 4'b1111;

   localparam logic [6:0] SEG_0    = 7'b1000000;
   localparam logic [6:0] SEG_1    = 7'b1111001;
   localparam logic [6:0] SEG_2    = 7'b0100100;
   localparam logic [6:0] SEG_3    = 7'b0110000;
   localparam logic [6:0] SEG_4    = 7'b0011001;
   localparam logic [6:0] SEG_5    = 7'b0010010;
   localparam logic [6:0] SEG_6    = 7'b0000010;
   localparam logic [6:0] SEG_7    = 7'b1111000;
   localparam logic [6:0] SEG_8    = 7'b0000000;
   localparam logic [6:0] SEG_9    = 7'b0010000;
   localparam logic [6:0] SEG_DASH = 7'b0111111;
   localparam logic [6:0] SEG_OFF  = 7'b1111111;

endpackage

// File: rtl/seg7_dec.sv
// seg7_dec: BCD nibble to active-low 7-segment pattern; 10..15 show "-".
// Ports: nib (in, 4), seg (out, 7, {g,f,e,d,c,b,a}).
module seg7_dec
   import seg_scan_4d_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      unique case (nib)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seg_scan_4d.sv
// seg_scan_4d: frame-synchronous 4-digit common-anode 7-seg scanner.
// Ports: clk, rst_n, bcd[15:0], bcd_valid, blank in; an[3:0], seg[6:0], dp, frame_start out.
module seg_scan_4d
   import seg_scan_4d_pkg::*;
#(
   parameter int CLK_HZ   = 50000000,
   parameter int DIGIT_HZ = 1000,
   parameter int DP_POS   = 3
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] bcd,
   input  logic        bcd_valid,
   input  logic        blank,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame_start
);

   localparam int RAW_DIV  = CLK_HZ / DIGIT_HZ;
   localparam int TICK_DIV = (RAW_DIV < 2) ? 2 : RAW_DIV;
   localparam int PW       = $clog2(TICK_DIV);

   logic [PW-1:0]    pre;
   logic [IDX_W-1:0] idx;
   logic [15:0]      shadow;
   logic [15:0]      pending;
   logic             pend_flag;
   logic             fs_arm;

   logic             tick;
   logic             boundary;
   logic [3:0]       nib;
   logic [6:0]       dec_seg;
   logic [3:0]       lz;
   logic             run;
   logic [3:0]       an_next;
   logic [6:0]       seg_next;
   logic             dp_next;

   assign tick     = (pre == PW'(TICK_DIV - 1));
   assign boundary = tick && (idx == IDX_W'(1));
   assign nib      = shadow[{idx, 2'b00} +: 4];

   seg7_dec u_dec (
      .nib (nib),
      .seg (dec_seg)
   );

   // A digit is blanked only while it and every higher digit are zero,
   // and only above the decimal-point position.
   always_comb begin
      lz  = 4'b0000;
      run = 1'b1;
      for (int d = 3; d >= 0; d--) begin
         run   = run && (d > DP_POS) && (shadow[4*d +: 4] == 4'd0);
         lz[d] = run;
      end
   end

   always_comb begin
      an_next  = blank ? AN_OFF : ~(4'b0001 << idx);
      seg_next = lz[idx] ? SEG_OFF : dec_seg;
      dp_next  = (idx == IDX_W'(DP_POS)) ? 1'b0 : 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre <= '0;
         idx <= '0;
      end else begin
         pre <= tick ? '0 : pre + PW'(1);
         if (tick)
            idx <= idx - IDX_W'(1);
      end
   end

   // Shadow only moves at the frame boundary; a strobe on that very
   // cycle bypasses the pending register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow    <= 16'h0000;
         pending   <= 16'h0000;
         pend_flag <= 1'b0;
      end else begin
         if (bcd_valid)
            pending <= bcd;
         if (boundary) begin
            pend_flag <= 1'b0;
            if (bcd_valid)
               shadow <= bcd;
            else if (pend_flag)
               shadow <= pending;
         end else if (bcd_valid) begin
            pend_flag <= 1'b1;
         end
      end
   end

   // fs_arm marks the first cycle of digit 0; it starts set so the
   // first frame after reset also gets its pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fs_arm      <= 1'b1;
         an          <= AN_OFF;
         seg         <= SEG_OFF;
         dp          <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         fs_arm      <= boundary;
         an          <= an_next;
         seg         <= seg_next;
         dp          <= dp_next;
         frame_start <= fs_arm;
      end
   end

endmodule
